sdram_port_arbiter: RTL and testbench

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

---
 rtl/sdram_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_port_arbiter
//
// Purpose:
//    Shares one 32-bit master port (towards a 32-to-16 SDRAM bridge) between
//    an instruction requester (i_*) and a data requester (d_*). A grant lasts
//    for one whole transfer and ends on m_compl. One RELEASE cycle with all
//    m_* outputs low follows every transfer, so the bridge always sees an idle
//    cycle between two transfers.
//
// Configuration:
//    SDRAM_ARB_ROUND_ROBIN_EN  defined   -> a tie goes to the port not served last
//                              undefined -> fixed priority, D wins every tie
//
// Ports:
//    clk, rst                        clock, asynchronous active-high reset
//    i_cs, i_wr_en, i_addr[31:0],    instruction requester request side
//    i_wdata[31:0], i_bytesel[3:0]
//    i_rdata[31:0], i_compl          instruction requester response side
//    d_*                             data requester, same shape as i_*
//    m_cs, m_wr_en, m_addr[31:0],    shared port to the bridge (outputs)
//    m_wdata[31:0], m_bytesel[3:0]
//    m_rdata[31:0], m_compl          shared port response (inputs)
// -----------------------------------------------------------------------------
module sdram_port_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_cs,
   input  logic        i_wr_en,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   input  logic [3:0]  i_bytesel,
   output logic [31:0] i_rdata,
   output logic        i_compl,
   input  logic        d_cs,
   input  logic        d_wr_en,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_bytesel,
   output logic [31:0] d_rdata,
   output logic        d_compl,
   output logic        m_cs,
   output logic        m_wr_en,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_bytesel,
   input  logic [31:0] m_rdata,
   input  logic        m_compl
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_next;
   logic   r_last_d;      // last-served pointer: 0 = I, 1 = D
   logic   w_i_req;
   logic   w_d_req;
   logic   w_tie_to_i;

   // A request with no byte lane enabled is not a request.
   assign w_i_req = i_cs & (|i_bytesel);
   assign w_d_req = d_cs & (|d_bytesel);

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
   // Alternate: after D was served, a tie goes to I, and vice versa.
   assign w_tie_to_i = r_last_d;
`else
   // Fixed priority: D always wins a tie. The pointer is still tracked so
   // both builds keep identical state; it simply has no effect here.
   assign w_tie_to_i = r_last_d & 1'b0;
`endif

   // State register and last-served pointer. Reset leaves the pointer on D so
   // that the first tie after reset goes to I in round-robin mode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_last_d <= 1'b1;
      end else begin
         r_state <= w_state_next;
         if (r_state == IDLE && w_state_next == GRANT_I) begin
            r_last_d <= 1'b0;
         end else if (r_state == IDLE && w_state_next == GRANT_D) begin
            r_last_d <= 1'b1;
         end
      end
   end

   // Next-state logic. Once granted, the transfer runs to m_compl even if the
   // requester drops its request, so a started bridge access is never aborted.
   // m_compl is only looked at in a grant state.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_i_req && w_d_req) begin
               w_state_next = w_tie_to_i ? GRANT_I : GRANT_D;
            end else if (w_i_req) begin
               w_state_next = GRANT_I;
            end else if (w_d_req) begin
               w_state_next = GRANT_D;
            end
         end
         GRANT_I, GRANT_D: begin
            if (m_compl) begin
               w_state_next = RELEASE;
            end
         end
         RELEASE: w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Output routing. m_cs is held high for the whole grant rather than
   // following X_cs, so the bridge keeps seeing the access after a requester
   // withdraws; the remaining request fields follow the granted port.
   always_comb begin
      m_cs      = 1'b0;
      m_wr_en   = 1'b0;
      m_addr    = 32'h0;
      m_wdata   = 32'h0;
      m_bytesel = 4'h0;
      i_rdata   = 32'h0;
      i_compl   = 1'b0;
      d_rdata   = 32'h0;
      d_compl   = 1'b0;
      case (r_state)
         GRANT_I: begin
            m_cs      = 1'b1;
            m_wr_en   = i_wr_en;
            m_addr    = i_addr;
            m_wdata   = i_wdata;
            m_bytesel = i_bytesel;
            i_rdata   = m_rdata;
            i_compl   = m_compl;
         end
         GRANT_D: begin
            m_cs      = 1'b1;
            m_wr_en   = d_wr_en;
            m_addr    = d_addr;
            m_wdata   = d_wdata;
            m_bytesel = d_bytesel;
            d_rdata   = m_rdata;
            d_compl   = m_compl;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
`timescale 1ns/1ps
module tb_sdram_port_arbiter;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        i_cs, i_wr_en, i_compl;
   logic [31:0] i_addr, i_wdata, i_rdata;
   logic [3:0]  i_bytesel;
   logic        d_cs, d_wr_en, d_compl;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [3:0]  d_bytesel;
   logic        m_cs, m_wr_en, m_compl;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic [3:0]  m_bytesel;

   always #5 clk = ~clk;

   sdram_port_arbiter dut (
      .clk(clk), .rst(rst),
      .i_cs(i_cs), .i_wr_en(i_wr_en), .i_addr(i_addr), .i_wdata(i_wdata),
      .i_bytesel(i_bytesel), .i_rdata(i_rdata), .i_compl(i_compl),
      .d_cs(d_cs), .d_wr_en(d_wr_en), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_bytesel(d_bytesel), .d_rdata(d_rdata), .d_compl(d_compl),
      .m_cs(m_cs), .m_wr_en(m_wr_en), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_bytesel(m_bytesel), .m_rdata(m_rdata), .m_compl(m_compl)
   );

   int n_checks = 0;
   int n_pass   = 0;
   bit cmp_en   = 1'b0;

   task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   // owner: 0 = nobody holds the port, 1 = I, 2 = D. gap: the idle cycle that
   // must follow every completed transfer before a new grant can be made.
   int mdl_owner  = 0;
   bit mdl_gap    = 1'b0;
   bit mdl_last_d = 1'b1;
   bit mdl_ir, mdl_dr;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mdl_owner = 0; mdl_gap = 1'b0; mdl_last_d = 1'b1;
      end else if (mdl_owner != 0) begin
         if (m_compl === 1'b1) begin mdl_owner = 0; mdl_gap = 1'b1; end
      end else if (mdl_gap) begin
         mdl_gap = 1'b0;
      end else begin
         mdl_ir = i_cs && (i_bytesel != 4'h0);
         mdl_dr = d_cs && (d_bytesel != 4'h0);
         if (mdl_ir && mdl_dr) mdl_owner = (RR && mdl_last_d) ? 1 : 2;
         else if (mdl_ir)      mdl_owner = 1;
         else if (mdl_dr)      mdl_owner = 2;
         if (mdl_owner != 0) mdl_last_d = (mdl_owner == 2);
      end
   end

   function automatic logic [135:0] model_out();
      logic        mc = 0, mw = 0, ic = 0, dc = 0;
      logic [31:0] ma = 0, md = 0, ir = 0, dr = 0;
      logic [3:0]  mb = 0;
      if (rst !== 1'b1 && mdl_owner == 1) begin
         mc = 1; mw = i_wr_en; ma = i_addr; md = i_wdata; mb = i_bytesel;
         ir = m_rdata; ic = m_compl;
      end else if (rst !== 1'b1 && mdl_owner == 2) begin
         mc = 1; mw = d_wr_en; ma = d_addr; md = d_wdata; mb = d_bytesel;
         dr = m_rdata; dc = m_compl;
      end
      return {mc, mw, ma, md, mb, ir, ic, dr, dc};
   endfunction

   // Compare process: every cycle, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en)
         check("cycle_outputs",
               {m_cs, m_wr_en, m_addr, m_wdata, m_bytesel, i_rdata, i_compl, d_rdata, d_compl},
               model_out());
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic idle_inputs();
      i_cs = 0; i_wr_en = 0; i_addr = 0; i_wdata = 0; i_bytesel = 0;
      d_cs = 0; d_wr_en = 0; d_addr = 0; d_wdata = 0; d_bytesel = 0;
      m_compl = 0; m_rdata = 0;
   endtask

   task automatic wait_grant();
      int waited = 0;
      tick(); @(negedge clk);
      while (m_cs !== 1'b1 && waited < 10) begin tick(); @(negedge clk); waited++; end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_addr;
      rst = 1'b1;
      idle_inputs();
      cmp_en = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", {m_cs, m_wr_en, m_addr, m_wdata, m_bytesel, i_compl, d_compl}, 0);
      #1 rst = 1'b0;

      // Single I read: request in cycle 0, grant from cycle 1, completion in cycle 4.
      tick(); i_cs = 1; i_addr = 32'h100; i_bytesel = 4'hF; i_wr_en = 0;
      @(negedge clk); check("i_read_latency", m_cs, 0);
      tick(); @(negedge clk); check("i_read_grant", {m_cs, m_addr, m_bytesel}, {1'b1, 32'h100, 4'hF});
      tick(); tick(); tick(); m_compl = 1; m_rdata = 32'hDEADBEEF;
      @(negedge clk); check("i_read_compl", {i_compl, i_rdata, d_compl}, {1'b1, 32'hDEADBEEF, 1'b0});
      tick(); m_compl = 0; m_rdata = 0; i_cs = 0;
      @(negedge clk); check("i_read_release", {m_cs, i_compl}, 0);

      // D write with d_cs withdrawn mid-transfer.
      tick(); d_cs = 1; d_wr_en = 1; d_addr = 32'h200; d_wdata = 32'h12345678; d_bytesel = 4'h3;
      tick(); @(negedge clk);
      check("d_write_grant", {m_cs, m_wr_en, m_addr, m_wdata, m_bytesel},
            {1'b1, 1'b1, 32'h200, 32'h12345678, 4'h3});
      tick(); d_cs = 0;
      @(negedge clk);
      check("d_write_held", {m_cs, m_wr_en, m_addr, m_wdata, m_bytesel},
            {1'b1, 1'b1, 32'h200, 32'h12345678, 4'h3});
      tick(); m_compl = 1;
      @(negedge clk); check("d_write_compl", {d_compl, i_compl}, {1'b1, 1'b0});
      tick(); m_compl = 0;
      @(negedge clk); check("d_write_release", m_cs, 0);
      tick(); @(negedge clk); check("d_write_idle", m_cs, 0);

      // Both ports requesting continuously.
      tick();
      i_cs = 1; i_addr = 32'h100; i_bytesel = 4'hF; i_wr_en = 0;
      d_cs = 1; d_addr = 32'h200; d_bytesel = 4'h3; d_wr_en = 0;
      for (int k = 0; k < 4; k++) begin
         wait_grant();
         exp_addr = (RR && (k % 2 == 0)) ? 32'h100 : 32'h200;
         check("tie_grant_order", {m_cs, m_addr}, {1'b1, exp_addr});
         tick(); m_compl = 1; @(negedge clk);
         tick(); m_compl = 0; @(negedge clk);
         check("tie_release_gap", m_cs, 0);
      end
      d_cs = 0;
      wait_grant();
      check("i_after_d_idle", {m_cs, m_addr}, {1'b1, 32'h100});
      tick(); m_compl = 1; i_cs = 0; d_cs = 1;
      tick(); m_compl = 0;

      // Reset while D holds the port, with I pending.
      wait_grant();
      check("d_before_reset", {m_cs, m_addr}, {1'b1, 32'h200});
      i_cs = 1;
      #2 rst = 1'b1;
      #1 check("reset_drops_m_cs", m_cs, 0);
      @(posedge clk); #3 rst = 1'b0; d_cs = 0;
      @(negedge clk); check("post_reset_idle", m_cs, 0);
      tick(); @(negedge clk); check("post_reset_i_grant", {m_cs, m_addr}, {1'b1, 32'h100});
      tick(); m_compl = 1; i_cs = 0;
      tick(); m_compl = 0;

      // Randomized traffic, checked by the compare process every cycle.
      for (int c = 0; c < 3000; c++) begin
         tick();
         if ($urandom_range(0, 3) == 0) i_cs = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) d_cs = 1'($urandom_range(0, 1));
         i_wr_en = 1'($urandom_range(0, 1)); d_wr_en = 1'($urandom_range(0, 1));
         i_addr = $urandom; i_wdata = $urandom; i_bytesel = 4'($urandom_range(0, 15));
         d_addr = $urandom; d_wdata = $urandom; d_bytesel = 4'($urandom_range(0, 15));
         m_compl = ($urandom_range(0, 3) == 0);
         m_rdata = $urandom;
         rst = ($urandom_range(0, 299) == 0);
      end
      tick(); rst = 0; idle_inputs();
      tick(); tick();
      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
